// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-master to one-slave memory arbiter. Grants are handed out
//             from IDLE with alternating priority on ties; the granted master
//             is passed straight through to the slave port. A per-transaction
//             wait counter forces an error completion when the slave stalls.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        err,
    input  logic        err_clr
);

    // Counter only needs to reach TIMEOUT; keep at least one bit when disabled.
    localparam int unsigned   CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam bit            C_TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_q,  last_d;    // 1 = m1 was granted most recently
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic           err_q,   err_d;

    // Signals of whichever master currently owns the slave port.
    logic           w_own_valid;
    logic [31:0]    w_own_addr;
    logic [31:0]    w_own_wdata;
    logic [3:0]     w_own_wstrb;
    logic           w_timeout;
    logic           w_done;
    logic [31:0]    w_rdata;

    // State, last-grant, wait counter and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, slave-port mux and master completion logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        s_valid     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_rdata    = '0;
        m1_rdata    = '0;

        w_own_valid = (state_q == GNT1) ? m1_valid : m0_valid;
        w_own_addr  = (state_q == GNT1) ? m1_addr  : m0_addr;
        w_own_wdata = (state_q == GNT1) ? m1_wdata : m0_wdata;
        w_own_wstrb = (state_q == GNT1) ? m1_wstrb : m0_wstrb;

        // A slave response in the same cycle as the limit wins over the timeout.
        w_timeout   = C_TO_EN && (state_q != IDLE) && w_own_valid &&
                      !s_ready && (cnt_q == C_TIMEOUT);
        w_done      = w_own_valid && (s_ready || w_timeout);
        w_rdata     = w_timeout ? ERR_DATA : s_rdata;

        // Timeout set takes priority over a simultaneous clear.
        if (w_timeout) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_valid && m1_valid) begin
                    if (last_q) begin
                        state_d = GNT0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = GNT1;
                        last_d  = 1'b1;
                    end
                end else if (m0_valid) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_valid) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                s_valid = w_own_valid && !w_timeout;
                s_addr  = w_own_addr;
                s_wdata = w_own_wdata;
                s_wstrb = w_own_wstrb;
                if (state_q == GNT0) begin
                    m0_ready = w_done;
                    m0_rdata = w_rdata;
                end else begin
                    m1_ready = w_done;
                    m1_rdata = w_rdata;
                end
                // Withdrawal or completion both release the port via IDLE.
                if (!w_own_valid || w_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant = {state_q == GNT1, state_q == GNT0};
    assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Randomised scoreboard bench for mem_arbiter with a reactive
//             slave model and a transaction/rule-level reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int unsigned TIMEOUT  = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        err;
    logic        err_clr;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .err(err), .err_clr(err_clr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;   // what the master must see
        bit          tmo;
        int          delay;
    } exp_t;

    exp_t expq0[$];
    exp_t expq1[$];

    int checks = 0;
    int errors = 0;

    // Stimulus control
    bit          busy[2];
    bit          ack[2];
    bit          drop[2];
    int          issue_left[2];
    int          force_delay[2];
    int          req_pct = 100;
    int          clr_pct = 0;
    int          dmin = 0;
    int          dmax = 2;
    int          txn_id = 0;
    logic [31:0] dir_addr = 32'h0;

    // Slave model state
    logic [31:0] rdata_of[logic [31:0]];
    int          delay_of[logic [31:0]];
    int          scnt = 0;
    logic [1:0]  sgrant_prev = 2'b00;

    // Monitor reference state
    logic [1:0]  pg = 2'b00;
    bit          p_m0v = 1'b0, p_m1v = 1'b0, pdone = 1'b0;
    bit          last_exp = 1'b1;
    bit          err_exp = 1'b0;
    int          gc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_valid(input int i, input logic v);
        if (i == 0) m0_valid = v; else m1_valid = v;
    endtask

    task automatic issue(input int i);
        exp_t        e;
        int          d;
        logic [31:0] rs;
        txn_id++;
        e.addr  = ((i == 0) ? 32'h0001_0000 : 32'h8001_0000) | (32'(txn_id) << 4);
        e.wstrb = 4'($urandom);
        if (i == 0 && dir_addr != 32'h0) begin
            e.addr   = dir_addr;
            e.wstrb  = 4'h0;
            dir_addr = 32'h0;
        end
        d       = (force_delay[i] >= 0) ? force_delay[i] : int'($urandom_range(dmax, dmin));
        e.wdata = $urandom;
        rs      = $urandom;
        e.tmo   = (d > int'(TIMEOUT));
        e.rdata = e.tmo ? ERR_DATA : rs;
        e.delay = d;
        rdata_of[e.addr] = rs;
        delay_of[e.addr] = d;
        if (i == 0) begin
            m0_addr = e.addr; m0_wdata = e.wdata; m0_wstrb = e.wstrb; m0_valid = 1'b1;
            expq0.push_back(e);
        end else begin
            m1_addr = e.addr; m1_wdata = e.wdata; m1_wstrb = e.wstrb; m1_valid = 1'b1;
            expq1.push_back(e);
        end
        busy[i] = 1'b1;
        issue_left[i]--;
    endtask

    // One clock of master behaviour followed by the reactive slave response.
    task automatic tick();
        exp_t        junk;
        logic [31:0] a;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (ack[i] || drop[i]) begin
                if (drop[i]) begin
                    if (i == 0 && expq0.size() > 0) junk = expq0.pop_back();
                    if (i == 1 && expq1.size() > 0) junk = expq1.pop_back();
                end
                ack[i]  = 1'b0;
                drop[i] = 1'b0;
                busy[i] = 1'b0;
                set_valid(i, 1'b0);
            end
            if (!busy[i] && issue_left[i] > 0 && int'($urandom_range(99, 0)) < req_pct)
                issue(i);
        end
        err_clr = (int'($urandom_range(99, 0)) < clr_pct);
        s_ready = 1'b0;
        #1;
        if (grant != 2'b00) begin
            scnt    = (sgrant_prev == 2'b00) ? 0 : scnt + 1;
            a       = grant[0] ? m0_addr : m1_addr;
            s_rdata = $urandom;
            if (delay_of.exists(a) && scnt == delay_of[a]) begin
                s_ready = 1'b1;
                s_rdata = rdata_of[a];
            end
        end else begin
            // Stray slave responses while idle must be ignored.
            s_ready = ($urandom_range(3, 0) == 0);
            s_rdata = $urandom;
        end
        sgrant_prev = grant;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy[0] || busy[1] || issue_left[0] > 0 || issue_left[1] > 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle budget expired actual=%0d required<%0d", n, budget);
        end
    endtask

    // Reference monitor: arbitration rules, pass-through, completion and err.
    task automatic mon_step();
        logic [1:0] gexp;
        bit         ov, ordy, ordy_exp, to_model;
        int         o;
        exp_t       e;
        if (pg == 2'b00) begin
            if (p_m0v && p_m1v) gexp = last_exp ? 2'b01 : 2'b10;
            else if (p_m0v)     gexp = 2'b01;
            else if (p_m1v)     gexp = 2'b10;
            else                gexp = 2'b00;
            if (gexp != 2'b00) last_exp = gexp[1];
        end else if (pdone) begin
            gexp = 2'b00;
        end else begin
            gexp = pg;
        end
        chk("grant", 32'(grant), 32'(gexp));
        gc       = (gexp == 2'b00) ? 0 : ((pg == 2'b00) ? 1 : gc + 1);
        to_model = 1'b0;
        ov       = 1'b0;
        ordy_exp = 1'b0;
        if (gexp == 2'b00) begin
            chk("idle_s_valid", 32'(s_valid), 32'(0));
            chk("idle_ready", 32'({m1_ready, m0_ready}), 32'(0));
        end else begin
            o        = gexp[1] ? 1 : 0;
            ov       = o ? m1_valid : m0_valid;
            ordy     = o ? m1_ready : m0_ready;
            to_model = ov && !s_ready && (gc == int'(TIMEOUT) + 1);
            ordy_exp = ov && (s_ready || to_model);
            chk("other_ready", 32'(o ? m0_ready : m1_ready), 32'(0));
            chk("own_ready", 32'(ordy), 32'(ordy_exp));
            if (ordy) begin
                checks++;
                if ((o == 0 && expq0.size() == 0) || (o == 1 && expq1.size() == 0)) begin
                    errors++;
                    $display("FAIL unexpected_ready master=%0d actual=1 required=0", o);
                end else begin
                    e = (o == 0) ? expq0.pop_front() : expq1.pop_front();
                    chk("rdata", o ? m1_rdata : m0_rdata, e.rdata);
                    chk("latency", 32'(gc), 32'(e.tmo ? int'(TIMEOUT) + 1 : e.delay + 1));
                    if (e.tmo) begin
                        chk("tmo_s_valid", 32'(s_valid), 32'(0));
                    end else begin
                        chk("s_valid", 32'(s_valid), 32'(1));
                        chk("s_addr", s_addr, e.addr);
                        chk("s_wdata", s_wdata, e.wdata);
                        chk("s_wstrb", 32'(s_wstrb), 32'(e.wstrb));
                    end
                end
                ack[o] = 1'b1;
            end else if (ov) begin
                chk("pass_valid", 32'(s_valid), 32'(1));
                chk("pass_addr", s_addr, o ? m1_addr : m0_addr);
            end else begin
                chk("withdraw_s_valid", 32'(s_valid), 32'(0));
            end
        end
        chk("err", 32'(err), 32'(err_exp));
        if (to_model)     err_exp = 1'b1;
        else if (err_clr) err_exp = 1'b0;
        pdone = (gexp != 2'b00) && (!ov || ordy_exp);
        pg    = gexp;
        p_m0v = m0_valid;
        p_m1v = m1_valid;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pg = 2'b00; p_m0v = 1'b0; p_m1v = 1'b0; pdone = 1'b0;
            last_exp = 1'b1; err_exp = 1'b0; gc = 0;
        end else begin
            mon_step();
        end
    end

    task automatic flush();
        expq0.delete();
        expq1.delete();
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; ack[i] = 1'b0; drop[i] = 1'b0;
            issue_left[i] = 0; force_delay[i] = -1;
            set_valid(i, 1'b0);
        end
        sgrant_prev = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0; err_clr = 1'b0;
        flush();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_s_valid", 32'(s_valid), 32'(0));
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        @(posedge clk); #1; rst = 1'b1;

        // Contention with continuous re-request: m0 first, then alternation.
        issue_left[0] = 12; issue_left[1] = 12; dmin = 0; dmax = 2;
        tick(); tick();
        chk("first_tie", 32'(grant), 32'(2'b01));
        wait_idle(400);

        // Single read at 0x100, slave ready two cycles after s_valid.
        dir_addr = 32'h100; force_delay[0] = 2; issue_left[0] = 1;
        tick();
        chk("rd_idle_grant", 32'(grant), 32'(0));
        tick();
        chk("rd_s_addr", s_addr, 32'h100);
        chk("rd_grant", 32'(grant), 32'(2'b01));
        wait_idle(50);
        force_delay[0] = -1;

        // Slave never responds: timeout, err set, then cleared.
        force_delay[1] = int'(TIMEOUT) + 5; issue_left[1] = 1;
        wait_idle(50);
        chk("err_set", 32'(err), 32'(1));
        clr_pct = 100; tick(); clr_pct = 0; tick();
        chk("err_cleared", 32'(err), 32'(0));
        force_delay[1] = -1;

        // Slave responds exactly in the timeout cycle.
        force_delay[0] = int'(TIMEOUT); issue_left[0] = 1;
        wait_idle(50);
        chk("edge_err", 32'(err), 32'(0));

        // Granted m0 withdraws; pending m1 served afterwards.
        force_delay[0] = 3; force_delay[1] = 0; issue_left[0] = 1;
        tick();
        issue_left[1] = 1;
        tick();
        chk("wd_grant0", 32'(grant), 32'(2'b01));
        drop[0] = 1'b1;
        tick();
        chk("wd_m0_ready", 32'(m0_ready), 32'(0));
        tick();
        chk("wd_idle", 32'(grant), 32'(0));
        tick();
        chk("wd_grant1", 32'(grant), 32'(2'b10));
        wait_idle(50);
        force_delay[0] = -1; force_delay[1] = -1;

        // Random traffic with random delays (including timeouts) and err_clr.
        issue_left[0] = 30; issue_left[1] = 30; req_pct = 50;
        dmin = 0; dmax = int'(TIMEOUT) + 2; clr_pct = 15;
        wait_idle(3000);
        clr_pct = 0; req_pct = 100; err_clr = 1'b0;

        // Asynchronous reset while m1 is mid-wait.
        force_delay[1] = 50; issue_left[1] = 1;
        tick(); tick(); tick();
        chk("pre_rst_grant", 32'(grant), 32'(2'b10));
        #1; rst = 1'b0; #1;
        chk("arst_s_valid", 32'(s_valid), 32'(0));
        chk("arst_ready", 32'({m1_ready, m0_ready}), 32'(0));
        chk("arst_grant", 32'(grant), 32'(0));
        flush();
        tick(); tick();
        @(posedge clk); #1; rst = 1'b1;
        issue_left[0] = 1; issue_left[1] = 1;
        tick(); tick();
        chk("post_rst_tie", 32'(grant), 32'(2'b01));
        wait_idle(50);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, maximum wait cycles for s_ready per granted transaction; 0 disables the timeout.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF, read data returned on a timed-out transaction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 m0_valid, m1_valid  input  1 each  master request, held high until the matching ready.
REQ-006 m0_addr, m1_addr, m0_wdata, m1_wdata  input  32 each  master address and write data.
REQ-007 m0_wstrb, m1_wstrb  input  4 each  byte write strobes; 0 means read.
REQ-008 m0_ready, m1_ready  output  1 each  one-cycle completion pulse to the master.
REQ-009 m0_rdata, m1_rdata  output  32 each  read data, valid only while the matching ready is high.
REQ-010 s_valid, s_addr, s_wdata, s_wstrb  output  1/32/32/4  shared slave port request.
REQ-011 s_ready, s_rdata  input  1/32  slave completion pulse and read data.
REQ-012 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 err  output  1  sticky timeout flag.
REQ-014 err_clr  input  1  synchronous clear of err.

Function
REQ-015 The FSM SHALL have states IDLE, GNT0 and GNT1.
REQ-016 In IDLE, the FSM SHALL move to GNT0 or GNT1 on the next edge if any mx_valid is high; s_valid SHALL be 0 in IDLE (1-cycle arbitration latency).
REQ-017 Single request: the requesting master SHALL be granted.
REQ-018 Simultaneous requests: the master not granted most recently SHALL be granted; the last-grant register SHALL be 1 after reset, so m0 wins the first tie.
REQ-019 In GNTx, s_valid/s_addr/s_wdata/s_wstrb SHALL combinationally equal mx_valid/addr/wdata/wstrb; the other master's ready SHALL stay 0.
REQ-020 In GNTx, mx_ready SHALL equal s_ready and mx_rdata SHALL equal s_rdata (zero added latency); on s_ready=1 the FSM SHALL return to IDLE.
REQ-021 A master re-requesting immediately after completion SHALL pass through IDLE, so the other pending master is granted next (strict alternation under contention).
REQ-022 The wait counter SHALL clear on entry to GNTx and increment each GNTx cycle with s_ready=0.
REQ-023 If TIMEOUT!=0 and the counter equals TIMEOUT with s_ready=0, the block SHALL force mx_ready=1 with mx_rdata=ERR_DATA, drive s_valid=0 that cycle, set err, and return to IDLE.
REQ-024 s_ready=1 in the timeout cycle SHALL take priority: normal completion, err unchanged.
REQ-025 If the granted mx_valid drops before completion, the FSM SHALL return to IDLE on the next edge without asserting mx_ready; err unchanged.
REQ-026 s_ready while in IDLE SHALL be ignored.
REQ-027 err_clr SHALL clear err unless a timeout sets it in the same cycle (set wins).
REQ-028 grant SHALL be 2'b01 in GNT0, 2'b10 in GNT1 and 2'b00 in IDLE, decoded from registered state.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, last-grant=1, counter=0, err=0, giving s_valid=0, m0_ready=m1_ready=0 and grant=2'b00, regardless of any transaction in flight.
REQ-030 After rst rises, the first arbitration SHALL occur on the first rising clk edge with a request present.

Verification
REQ-031 m0 read at 0x100 with slave ready 2 cycles after s_valid -> s_addr=0x100 one cycle after m0_valid, m0_ready pulses once with m0_rdata=s_rdata, grant 01 then 00.
REQ-032 m0 and m1 request together and re-request continuously -> first grant m0, then strict m1/m0 alternation; no ready reaches the non-granted master.
REQ-033 TIMEOUT=4 and slave never ready -> m1_ready pulses with m1_rdata=0xDEADBEEF on the 5th GNT cycle, err=1, s_valid=0 in that cycle; err_clr then drops err.
REQ-034 s_ready asserted exactly in the timeout cycle -> normal data returned, err stays 0.
REQ-035 rst pulled low while in GNT1 mid-wait -> s_valid, ready and grant drop at once; after release, a tie grants m0.
REQ-036 Granted m0 withdraws valid before s_ready -> no m0_ready, FSM is IDLE next cycle, pending m1 is granted after that.
